layer1_pool_buffer: RTL and testbench

LAYER1_POOL_BUFFER -- requirements
Module: layer1_pool_buffer

---
 rtl/layer1_pool_buffer.sv | 129 ++++++++++++
 tb/tb_layer1_pool_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer1_pool_buffer.sv
// Single-frame buffer between the layer-1 maxpool stage and its consumer.
// Collects one MAP_SIZE x MAP_SIZE frame of pooled samples, then presents the
// frame in raster order through a valid/ready handshake, pulses frame_done
// once the frame has left, and goes back to collecting the next frame.
module layer1_pool_buffer #(
  parameter int MAP_SIZE   = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] datain,
  input  logic                         pool_out,
  input  logic                         rd_ready,
  output logic signed [DATA_WIDTH-1:0] dataout,
  output logic                         data_valid,
  output logic [3:0]                   out_row,
  output logic [3:0]                   out_col,
  output logic                         frame_done,
  output logic                         overflow
);

  localparam int DEPTH = MAP_SIZE * MAP_SIZE;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [3:0]    LAST_POS  = 4'(MAP_SIZE - 1);

  typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [AW-1:0]                mem_addr_wr;
  logic [AW-1:0]                rd_addr;
  logic [AW-1:0]                rd_sel;
  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  logic write_en;
  logic last_write;
  logic transfer;
  logic last_xfer;
  logic load_first;
  logic read_en;

  // Handshake qualifiers; everything is gated by enable so a low enable freezes the block.
  always_comb begin
    write_en   = enable && pool_out && (state == FILL);
    last_write = write_en && (mem_addr_wr == LAST_ADDR);
    // First DRAIN cycle: nothing is presented yet, so prime dataout from address 0.
    load_first = enable && (state == DRAIN) && !data_valid;
    transfer   = enable && (state == DRAIN) && data_valid && rd_ready;
    last_xfer  = transfer && (rd_addr == LAST_ADDR);
    // Single read port: either the primed address or the one after the current sample.
    read_en    = load_first || (transfer && !last_xfer);
    rd_sel     = load_first ? rd_addr : rd_addr + 1'b1;
  end

  // Next-state logic for the fill/drain/done sequence.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (last_write) state_next = DRAIN;
      DRAIN:   if (last_xfer)  state_next = DONE;
      DONE:    if (enable)     state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  // Frame storage; contents are deliberately not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (!reset && write_en) mem[mem_addr_wr] <= datain;
  end

  // Write pointer, wraps after the final sample of a frame.
  always_ff @(posedge clk) begin
    if (reset)           mem_addr_wr <= '0;
    else if (last_write) mem_addr_wr <= '0;
    else if (write_en)   mem_addr_wr <= mem_addr_wr + 1'b1;
  end

  // Registered array read feeding the output sample.
  always_ff @(posedge clk) begin
    if (reset)        dataout <= '0;
    else if (read_en) dataout <= mem[rd_sel];
  end

  // Read pointer, valid flag and raster position of the presented sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr    <= '0;
      data_valid <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
    end else if (load_first) begin
      data_valid <= 1'b1;
    end else if (last_xfer) begin
      rd_addr    <= '0;
      data_valid <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
    end else if (transfer) begin
      rd_addr <= rd_addr + 1'b1;
      if (out_col == LAST_POS) begin
        out_col <= '0;
        out_row <= out_row + 1'b1;
      end else begin
        out_col <= out_col + 1'b1;
      end
    end
  end

  // frame_done is high exactly while the DONE state is occupied.
  always_ff @(posedge clk) begin
    if (reset)       frame_done <= 1'b0;
    else if (enable) frame_done <= last_xfer;
  end

  // Sticky flag for write strobes that arrive while the buffer is not accepting.
  always_ff @(posedge clk) begin
    if (reset)                                       overflow <= 1'b0;
    else if (enable && pool_out && (state != FILL))  overflow <= 1'b1;
  end

endmodule

// File: tb/tb_layer1_pool_buffer.sv
// Self-checking bench for layer1_pool_buffer: written samples go into a
// scoreboard queue and are popped as each transfer is observed on the output.
module tb_layer1_pool_buffer;

  localparam int N = 144;
  localparam int MS = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic pool_out = 1'b0;
  logic rd_ready = 1'b0;
  logic signed [15:0] datain = '0;
  logic signed [15:0] dataout;
  logic data_valid;
  logic [3:0] out_row;
  logic [3:0] out_col;
  logic frame_done;
  logic overflow;

  int checks = 0;
  int errors = 0;
  logic signed [15:0] sb[$];

  always #5 clk = ~clk;

  layer1_pool_buffer #(.MAP_SIZE(MS), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .datain(datain),
    .pool_out(pool_out), .rd_ready(rd_ready), .dataout(dataout),
    .data_valid(data_valid), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done), .overflow(overflow)
  );

  // Write one full frame; mode 1 = ramp from base, otherwise random values.
  task automatic write_frame(input bit ramp, input int base, input bit pause);
    logic signed [15:0] v;
    for (int i = 0; i < N; i++) begin
      if (pause && i == 70) begin
        for (int p = 0; p < 5; p++) begin
          @(negedge clk);
          checks++;
          if (data_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL fill_hold: data_valid=%0b frame_done=%0b required 0/0", data_valid, frame_done);
          end
          enable = 1'b0; pool_out = 1'b1; datain = 16'sh1234;
        end
      end
      @(negedge clk);
      enable = 1'b1; pool_out = 1'b1; rd_ready = 1'b1;
      v = ramp ? 16'(base + i) : 16'($urandom);
      datain = v;
      sb.push_back(v);
    end
    @(negedge clk);
    pool_out = 1'b0;
  endtask

  // Write a partial frame that is expected to be discarded (not scoreboarded).
  task automatic write_partial(input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      enable = 1'b1; pool_out = 1'b1; datain = 16'($urandom);
    end
    @(negedge clk);
    pool_out = 1'b0;
  endtask

  // Drain one frame, comparing each transfer against the scoreboard.
  task automatic drain(input bit rnd, input bit pause, input bit inject);
    int k = 0;
    int pause_cnt = 0;
    bit done = 0;
    bit prev_valid = 0;
    bit prev_xfer = 0;
    bit prev_last = 0;
    bit xfer;
    logic signed [15:0] prev_data = '0;
    logic signed [15:0] exp_v;
    logic [3:0] prev_row = '0;
    logic [3:0] prev_col = '0;
    logic [3:0] last_row = '0;
    logic [3:0] last_col = '0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        checks++;
        if (!prev_last) begin
          errors++;
          $display("FAIL frame_done_timing: pulse at transfer %0d, required after transfer %0d", k, N);
        end
        checks++;
        if (data_valid !== 1'b0) begin
          errors++;
          $display("FAIL done_valid: data_valid=%0b required 0", data_valid);
        end
        done = 1;
      end else if (prev_last) begin
        checks++; errors++;
        $display("FAIL frame_done_missing: frame_done=%0b required 1", frame_done);
        done = 1;
      end
      if (!done) begin
        if (prev_valid && !prev_xfer && data_valid) begin
          checks++;
          if (dataout !== prev_data || out_row !== prev_row || out_col !== prev_col) begin
            errors++;
            $display("FAIL hold_stable: data=%0d r=%0d c=%0d required data=%0d r=%0d c=%0d",
                     dataout, out_row, out_col, prev_data, prev_row, prev_col);
          end
        end
        if (!rnd && !pause && k > 0 && k < N) begin
          checks++;
          if (data_valid !== 1'b1) begin
            errors++;
            $display("FAIL continuous: data_valid=%0b required 1 at transfer %0d", data_valid, k);
          end
        end
        if (pause && k == 50 && pause_cnt < 5) begin
          enable = 1'b0; pause_cnt++;
        end else begin
          enable = 1'b1;
        end
        rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pool_out = inject && k >= 20 && k < 23;
        datain = 16'sh7FFF;
        xfer = enable && (data_valid === 1'b1) && rd_ready;
        if (xfer) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL extra_sample: data=%0d required no transfer", dataout);
          end else begin
            exp_v = sb.pop_front();
            if (dataout !== exp_v || out_row !== 4'(k / MS) || out_col !== 4'(k % MS)) begin
              errors++;
              $display("FAIL sample_%0d: data=%0d r=%0d c=%0d required data=%0d r=%0d c=%0d",
                       k, dataout, out_row, out_col, exp_v, k / MS, k % MS);
            end
          end
          $display("xfer %0d row=%0d col=%0d data=%0d", k, out_row, out_col, dataout);
          last_row = out_row; last_col = out_col;
          k++;
        end
        prev_valid = data_valid; prev_xfer = xfer; prev_last = xfer && (k == N);
        prev_data = dataout; prev_row = out_row; prev_col = out_col;
      end
    end
    checks++;
    if (!done || k != N || sb.size() != 0) begin
      errors++;
      $display("FAIL drain_complete: transfers=%0d left=%0d done=%0b required %0d/0/1", k, sb.size(), done, N);
    end
    checks++;
    if (last_row !== 4'd11 || last_col !== 4'd11) begin
      errors++;
      $display("FAIL last_position: r=%0d c=%0d required 11/11", last_row, last_col);
    end
    enable = 1'b1; pool_out = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (dataout !== 16'sd0 || data_valid !== 1'b0 || out_row !== 4'd0 || out_col !== 4'd0 ||
        frame_done !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s: data=%0d v=%0b r=%0d c=%0d fd=%0b ov=%0b required all 0",
               name, dataout, data_valid, out_row, out_col, frame_done, overflow);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b1; pool_out = 1'b1; rd_ready = 1'b1; datain = 16'sd5;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset_state");
    reset = 1'b0; pool_out = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_full_frame();
    write_frame(1'b1, -72, 1'b0);
    drain(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random_ready();
    write_frame(1'b0, 0, 1'b0);
    drain(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_pre: overflow=%0b required 0", overflow);
    end
    write_frame(1'b0, 0, 1'b0);
    drain(1'b0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: overflow=%0b required 1", overflow);
    end
  endtask

  task automatic test_enable_hold();
    write_frame(1'b0, 0, 1'b1);
    drain(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    write_partial(70);
    @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    check_idle("midframe_reset");
    reset = 1'b0; enable = 1'b1;
    write_frame(1'b0, 0, 1'b0);
    drain(1'b1, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_after_reset: overflow=%0b required 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    write_frame(1'b0, 0, 1'b0);
    drain(1'b0, 1'b0, 1'b0);
    write_frame(1'b1, 1000, 1'b0);
    drain(1'b0, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_overflow: overflow=%0b required 0", overflow);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_ready();
    test_overflow();
    test_enable_hold();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
